// File: rtl/uart_rx_deframer.sv
// 8N1 UART receive deframer: synchronises the serial line, validates the start bit
// at mid-bit, samples data/stop at bit centres and presents bytes behind valid/ack.
module uart_rx_deframer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int H     = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_rx_p0;
  logic             r_rx_p1;
  logic             w_rx_s;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_ferr;
  logic             r_over;
  logic             w_cnt_clr;
  logic             w_shift_en;
  logic             w_deliver;
  logic             w_accept;

  assign w_rx_s    = r_rx_p1;
  assign w_accept  = !r_valid || rx_ack;
  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_over;
  assign busy      = (r_state != S_IDLE);

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_p0 <= 1'b1;
      r_rx_p1 <= 1'b1;
    end else begin
      r_rx_p0 <= rx;
      r_rx_p1 <= r_rx_p0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_deliver   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = S_START;
          w_cnt_clr   = 1'b1;
        end
      end
      S_START: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == CNT_FULL) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (r_cnt == CNT_FULL) begin
          w_cnt_clr   = 1'b1;
          w_deliver   = 1'b1;
          w_state_nxt = w_rx_s ? S_IDLE : S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        if (w_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bit timing and LSB-first shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
    end else begin
      if (w_cnt_clr || r_state == S_IDLE) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == S_IDLE) begin
        r_idx <= 3'd0;
      end else if (w_shift_en) begin
        r_idx <= r_idx + 3'd1;
      end
      if (w_shift_en) begin
        r_shift <= {w_rx_s, r_shift[7:1]};
      end
    end
  end

  // Host handshake: a delivery in the ack cycle replaces the consumed byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_over  <= 1'b0;
    end else if (w_deliver) begin
      if (w_accept) begin
        r_data  <= r_shift;
        r_ferr  <= ~w_rx_s;
        r_valid <= 1'b1;
        if (rx_ack && r_valid) begin
          r_over <= 1'b0;
        end
      end else begin
        r_over <= 1'b1;
      end
    end else if (rx_ack && r_valid) begin
      r_valid <= 1'b0;
      r_over  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed + randomized bench for uart_rx_deframer with a host-level byte/handshake model.
module tb_uart_rx_deframer;

  localparam int CPB = 16;
  localparam int H   = CPB / 2;
  localparam int LAT = 2 + H + 9 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int lat_edges;

  logic [7:0] m_data = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ferr = 1'b0;
  logic       m_over = 1'b0;

  always #5 clk = ~clk;

  uart_rx_deframer #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .rx_ack   (rx_ack),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".data"},    {24'd0, rx_data},   {24'd0, m_data});
    chk({tag, ".valid"},   {31'd0, rx_valid},  {31'd0, m_valid});
    chk({tag, ".ferr"},    {31'd0, frame_err}, {31'd0, m_ferr});
    chk({tag, ".overrun"}, {31'd0, overrun},   {31'd0, m_over});
  endtask

  task automatic model_reset();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    m_over  = 1'b0;
  endtask

  // Drives one 8N1 frame; optionally acks in the cycle the byte is delivered.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic ack_on);
    logic [9:0] bits;
    logic       prev;
    int         t;
    bits      = {stop, b, 1'b0};
    t         = 0;
    lat_edges = -1;
    prev      = rx_valid;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < CPB; c++) begin
        rx     = bits[i];
        rx_ack = ack_on && (t == LAT);
        tick();
        t++;
        if (lat_edges < 0 && !prev && rx_valid) lat_edges = t - 1;
        prev = rx_valid;
      end
    end
    rx_ack = 1'b0;
    rx     = 1'b1;
    if (!m_valid || ack_on) begin
      m_data  = b;
      m_ferr  = ~stop;
      m_valid = 1'b1;
      if (ack_on) m_over = 1'b0;
    end else begin
      m_over = 1'b1;
    end
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_over  = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs;
    logic [9:0] fbits;

    // Reset held while the line toggles
    for (int i = 0; i < 8; i++) begin
      rx = ~rx;
      tick();
    end
    chk_outputs("reset_hold");
    chk("reset_hold.busy", {31'd0, busy}, 32'd0);
    rx    = 1'b1;
    reset = 1'b0;
    repeat (20) tick();
    chk("idle_after_reset.busy", {31'd0, busy}, 32'd0);
    chk_outputs("idle_after_reset");

    // Clean 0x55 with exact latency, then ack
    send_frame(8'h55, 1'b1, 1'b0);
    chk("clean55.latency", lat_edges, LAT);
    chk_outputs("clean55");
    do_ack();
    chk_outputs("clean55_ack");

    // False start: 5 low cycles
    rx = 1'b0;
    repeat (5) tick();
    rx = 1'b1;
    repeat (H + 2 - 5) tick();
    chk("false_start.busy_at_check", {31'd0, busy}, 32'd1);
    tick();
    chk("false_start.busy_after", {31'd0, busy}, 32'd0);
    repeat (30) tick();
    chk("false_start.busy_idle", {31'd0, busy}, 32'd0);
    chk_outputs("false_start");

    // Framing error followed by a break
    send_frame(8'hA3, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (40) tick();
    chk_outputs("break_low");
    chk("break_low.busy", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    repeat (4) tick();
    chk("break_release.busy", {31'd0, busy}, 32'd0);
    chk_outputs("break_release");
    do_ack();
    chk_outputs("break_ack");

    // Overrun: back-to-back without ack
    send_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0);
    chk_outputs("overrun_p1");
    do_ack();
    chk_outputs("overrun_p1_ack");

    // Ack in the delivery cycle of the second byte
    send_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1'b1);
    chk_outputs("overrun_p2");
    do_ack();
    chk_outputs("overrun_p2_ack");

    // Randomized bytes and stop bits with random idle gaps
    for (int k = 0; k < 6; k++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rb, rs, 1'b0);
      chk("rand.latency", lat_edges, LAT);
      chk_outputs("rand");
      repeat (4 + $urandom_range(0, 20)) tick();
      do_ack();
      chk_outputs("rand_ack");
    end

    // Reset during data bit 4 of 0xF0
    fbits = {1'b1, 8'hF0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < CPB; c++) begin
        if (i < 5 || c < H) begin
          rx = fbits[i];
          tick();
        end
      end
    end
    #2;
    reset = 1'b1;
    #1;
    chk("midreset.busy_async", {31'd0, busy}, 32'd0);
    model_reset();
    chk_outputs("midreset_async");
    tick();
    rx = 1'b1;
    tick();
    reset = 1'b0;
    repeat (20) tick();
    chk_outputs("midreset_release");
    send_frame(8'h0F, 1'b1, 1'b0);
    chk("after_reset.latency", lat_edges, LAT);
    chk_outputs("after_reset");
    do_ack();
    chk_outputs("after_reset_ack");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

Serial-to-parallel receive stage that consumes the `Tx` line of a `uart` instance and turns 8N1 frames into bytes for the host side. It synchronises the asynchronous line and validates the start bit at mid-bit. It samples data and stop bits at bit centres. Each byte is presented behind a valid/ack handshake, with framing-error and overrun status.

## Interface
- `CLKS_PER_BIT`, 16, clock cycles per serial bit; even, ≥ 4; H = CLKS_PER_BIT/2.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `rx_ack`  in  1  host consumed `rx_data`; single-cycle pulse or level.
- `rx_data`  out  8  last accepted byte, LSB = first data bit.
- `rx_valid`  out  1  `rx_data` holds an unread byte.
- `frame_err`  out  1  stop bit of the byte in `rx_data` was 0.
- `overrun`  out  1  sticky; a byte completed while `rx_valid`=1 and was dropped.
- `busy`  out  1  FSM not in IDLE.

## Operation
- Reset values: `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0, FSM=IDLE. The synchroniser flops are set to 1.
- `rx` passes through a 2-flop synchroniser to give `rx_s`. Only `rx_s` is used internally.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when `rx_s`=0, go to START, clear the bit counter `cnt` to 0 and clear the bit index to 0.
  - START: `cnt` increments each cycle. At `cnt`=H-1, sample `rx_s`. If 1, it is a false start: go to IDLE. If 0, go to DATA with `cnt`=0.
  - DATA: at `cnt`=CLKS_PER_BIT-1, shift `rx_s` into the MSB of the shift register (a right shift, so LSB-first data lands correctly). Then increment the index and clear `cnt`. After the 8th sample, go to STOP.
  - STOP: at `cnt`=CLKS_PER_BIT-1, sample the stop bit and perform the deliver step. Then go to IDLE if the stop bit was 1, or WAIT_HIGH if it was 0.
  - WAIT_HIGH: stay until `rx_s`=1 (break or line low), then go to IDLE. No new start is detected in this state.
- Deliver step (one cycle):
  - If `rx_valid`=0, or `rx_ack`=1 in the same cycle: load `rx_data` from the shift register, load `frame_err` with the inverted stop bit, and set `rx_valid`=1.
  - Otherwise: drop the byte, set `overrun`=1, and leave `rx_data`/`frame_err` unchanged.
- Handshake: `rx_ack`=1 while `rx_valid`=1 clears `rx_valid` and `overrun` on the next edge, unless a delivery happens on that same edge. In that case `rx_valid` stays 1 and the new byte is loaded.
- `rx_ack` while `rx_valid`=0 is ignored.
- `frame_err` describes the byte currently in `rx_data` only. It is not sticky.
- The receiver keeps running regardless of the host. The shift register is internal until delivery.

## Timing
- Reset assertion clears state asynchronously, mid-frame included. After release, the FSM starts in IDLE, so a frame already in progress is treated as a fresh start only at the next falling edge seen in IDLE.
- Start detection happens 2 edges after `rx` falls, because of the synchroniser.
- Latency:
  - From the first `clk` edge that registers `rx`=0 into sync stage 1, to `rx_valid` high: 2 + H + 9·CLKS_PER_BIT edges.
  - With CLKS_PER_BIT=16, that is 154 edges.
- The stop bit is sampled at its centre, so the FSM is back in IDLE H cycles before the nominal frame end. Back-to-back frames with zero idle time are received without loss.
- Tolerated baud mismatch is about ±4% with CLKS_PER_BIT=16.
- `busy` is combinationally decoded from the FSM state: 0 in IDLE, 1 otherwise.

## Test plan
- Reset behaviour:
  - Stimulus: hold `reset`=1 with `rx` toggling.
  - Required: all outputs 0 and `busy`=0. After release with `rx`=1, no activity.
- Single clean byte at CLKS_PER_BIT=16:
  - Stimulus: send 0x55 (start 0, bits 1,0,1,0,1,0,1,0, stop 1).
  - Required: `rx_valid` rises exactly 154 edges after the fall, with `rx_data`=0x55 and `frame_err`=0. Then pulse `rx_ack` and check `rx_valid`=0 on the next edge.
- False start:
  - Stimulus: drive `rx` low for 5 cycles, then high.
  - Required: FSM returns to IDLE at the H-1 check, `rx_valid` stays 0, and `busy` drops 1 cycle after the check.
- Framing error and break:
  - Stimulus: send 0xA3 with stop=0, then hold `rx` low for 40 cycles.
  - Required: `rx_data`=0xA3, `frame_err`=1, `rx_valid`=1. FSM stays in WAIT_HIGH until `rx` goes high, and no second byte is delivered.
- Overrun and simultaneous ack:
  - Part 1: send 0x12 and 0x34 back-to-back with no ack. Required: `rx_data`=0x12 and `overrun`=1.
  - Part 2: repeat, but assert `rx_ack` in the delivery cycle of 0x34. Required: `rx_data`=0x34, `rx_valid`=1, `overrun`=0.
- Reset mid-frame:
  - Stimulus: assert `reset` during data bit 4 of 0xF0, release it, then send 0x0F.
  - Required: 0xF0 is never delivered, 0x0F is received correctly, and `overrun`=0.
